regfile_wb_arbiter: RTL

REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

---
 rtl/regfile_wb_arbiter.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/regfile_wb_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_wb_arbiter
//  Description : Two-requester register-file writeback arbiter. Requester A
//                (ALU) and B (load) compete for the single write port. The
//                winning write is registered and presented one cycle later.
//                Writes to x0 are accepted but never enabled. A saturating
//                counter tallies contended cycles.
//                Build option: define REGFILE_WB_ARB_ROUND_ROBIN_EN for
//                round-robin priority; otherwise A wins every contention.
//  Revision    : 1.0 - initial release
// ============================================================================
module regfile_wb_arbiter #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              a_valid,
    output logic              a_ready,
    input  logic [ADDR_W-1:0] a_rd_addr,
    input  logic [DATA_W-1:0] a_rd_data,
    input  logic              b_valid,
    output logic              b_ready,
    input  logic [ADDR_W-1:0] b_rd_addr,
    input  logic [DATA_W-1:0] b_rd_data,
    input  logic              stall,
    output logic              we,
    output logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data,
    output logic [CNT_W-1:0]  conflict_cnt
);

    localparam logic [CNT_W-1:0] c_CNT_MAX = '1;

    logic              w_grant_a;
    logic              w_grant_b;
    logic              w_prio_b;
    logic              w_contend;

    logic              we_q;
    logic              we_d;
    logic [ADDR_W-1:0] rd_addr_q;
    logic [ADDR_W-1:0] rd_addr_d;
    logic [DATA_W-1:0] rd_data_q;
    logic [DATA_W-1:0] rd_data_d;
    logic [CNT_W-1:0]  cnt_q;
    logic [CNT_W-1:0]  cnt_d;

    // A cycle is contended whenever both requesters want the port and the
    // pipeline is not stalled, regardless of who ends up winning.
    assign w_contend = a_valid && b_valid && !stall;

`ifdef REGFILE_WB_ARB_ROUND_ROBIN_EN
    localparam logic [0:0] c_PRIO_A = 1'b0;
    localparam logic [0:0] c_PRIO_B = 1'b1;

    logic [0:0] prio_q;
    logic [0:0] prio_d;

    // Priority pointer register; favours A out of reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            prio_q <= c_PRIO_A;
        end else begin
            prio_q <= prio_d;
        end
    end

    // After any transfer, hand priority to the requester that lost out.
    always_comb begin
        prio_d = prio_q;
        if (w_grant_a) begin
            prio_d = c_PRIO_B;
        end else if (w_grant_b) begin
            prio_d = c_PRIO_A;
        end
    end

    assign w_prio_b = (prio_q == c_PRIO_B);
`else
    assign w_prio_b = 1'b0;
`endif

    // Grant decision: nothing during reset or stall, the sole requester if
    // only one is valid, otherwise whoever the pointer favours.
    always_comb begin
        w_grant_a = 1'b0;
        w_grant_b = 1'b0;
        if (!rst && !stall) begin
            if (a_valid && b_valid) begin
                w_grant_a = !w_prio_b;
                w_grant_b = w_prio_b;
            end else begin
                w_grant_a = a_valid;
                w_grant_b = b_valid;
            end
        end
    end

    assign a_ready = w_grant_a;
    assign b_ready = w_grant_b;

    // Next write-port contents: capture the granted request, hold otherwise.
    // A write to x0 completes its handshake but never raises the enable.
    always_comb begin
        we_d      = 1'b0;
        rd_addr_d = rd_addr_q;
        rd_data_d = rd_data_q;
        if (w_grant_a) begin
            we_d      = (a_rd_addr != '0);
            rd_addr_d = a_rd_addr;
            rd_data_d = a_rd_data;
        end else if (w_grant_b) begin
            we_d      = (b_rd_addr != '0);
            rd_addr_d = b_rd_addr;
            rd_data_d = b_rd_data;
        end
    end

    // Saturating contention counter next value.
    always_comb begin
        cnt_d = cnt_q;
        if (w_contend && (cnt_q != c_CNT_MAX)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Write-port and counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            we_q      <= 1'b0;
            rd_addr_q <= '0;
            rd_data_q <= '0;
            cnt_q     <= '0;
        end else begin
            we_q      <= we_d;
            rd_addr_q <= rd_addr_d;
            rd_data_q <= rd_data_d;
            cnt_q     <= cnt_d;
        end
    end

    assign we           = we_q;
    assign rd_addr      = rd_addr_q;
    assign rd_data      = rd_data_q;
    assign conflict_cnt = cnt_q;

endmodule
`default_nettype wire
